// File: rtl/midi_note_rx.sv
// midi_note_rx: MIDI serial receiver with running-status note-on parser.
// Deserialises the line (8N1, LSB first), tracks running status and emits a
// one-cycle midi_ready pulse with the key on midi_index for each accepted
// note-on (key in [NOTE_MIN,NOTE_MAX], velocity non-zero).
// Build option: define MIDI_CHANNEL_FILTER_EN to accept note-on only on
// channel CHANNEL; otherwise every channel is accepted.
module midi_note_rx #(
  parameter int CLK_FREQ = 65_000_000,
  parameter int BAUD     = 31250,
  parameter int NOTE_MIN = 48,
  parameter int NOTE_MAX = 79,
  parameter int CHANNEL  = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_in,
  output logic [6:0] midi_index,
  output logic       midi_ready,
  output logic       frame_err
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD;
  localparam int HALF_TICKS = (BIT_TICKS / 2 < 1) ? 1 : BIT_TICKS / 2;
  localparam int CW         = (BIT_TICKS < 2) ? 1 : $clog2(BIT_TICKS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);
  localparam logic [6:0]    KEY_LO    = 7'(NOTE_MIN);
  localparam logic [6:0]    KEY_HI    = 7'(NOTE_MAX);

  // A channel outside 0..15 can never match a status nibble.
  if (CHANNEL < 0 || CHANNEL > 15) begin : g_channel_range
    $error("midi_note_rx: CHANNEL must be 0..15");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_NOTE_ON,
    ST_OTHER
  } run_status_e;

  typedef enum logic {
    PH_KEY,
    PH_VEL
  } data_phase_e;

  // ---------------------------------------------------------------------------
  // Line synchroniser (idle-high reset so reset never looks like a start bit)
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       line;

  // Shift the raw line through two flops before anything looks at it.
  always_comb begin
    sync_d = {sync_q[0], midi_in};
  end

  assign line = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_vld_q, byte_vld_d;
  logic        frame_err_q, frame_err_d;

  // Bit timing: find the start edge, re-check at mid start bit, then sample
  // each following bit one bit period later (i.e. near its centre).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!line) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again by mid start bit was noise.
          state_d   = line ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {line, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (line) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte parser
  // ---------------------------------------------------------------------------
  run_status_e status_q, status_d;
  data_phase_e phase_q, phase_d;
  logic [6:0]  key_q, key_d;
  logic [6:0]  index_q, index_d;
  logic        ready_q, ready_d;
  logic        chan_ok;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = (byte_q[3:0] == 4'(CHANNEL));
`else
  assign chan_ok = 1'b1;
`endif

  // Running-status interpreter: status bytes set the mode, data bytes
  // alternate key/velocity while note-on status is in force.
  always_comb begin
    status_d = status_q;
    phase_d  = phase_q;
    key_d    = key_q;
    index_d  = index_q;
    ready_d  = 1'b0;
    if (frame_err_q) begin
      // A corrupted byte may have been a key or velocity; resync on a key.
      phase_d = PH_KEY;
    end else if (byte_vld_q) begin
      if (byte_q[7]) begin
        if (byte_q[7:3] == 5'b11111) begin
          // Real-time messages may interleave anywhere; leave state alone.
        end else if (byte_q[7:4] == 4'hF) begin
          status_d = ST_NONE;
          phase_d  = PH_KEY;
        end else if (byte_q[7:4] == 4'h9 && chan_ok) begin
          status_d = ST_NOTE_ON;
          phase_d  = PH_KEY;
        end else begin
          status_d = ST_OTHER;
          phase_d  = PH_KEY;
        end
      end else if (status_q == ST_NOTE_ON) begin
        if (phase_q == PH_KEY) begin
          key_d   = byte_q[6:0];
          phase_d = PH_VEL;
        end else begin
          phase_d = PH_KEY;
          // Velocity zero is a note-off in disguise.
          if (byte_q[6:0] != 7'd0 && key_q >= KEY_LO && key_q <= KEY_HI) begin
            index_d = key_q;
            ready_d = 1'b1;
          end
        end
      end
    end
  end

  // All state registers, cleared together by the synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      status_q    <= ST_NONE;
      phase_q     <= PH_KEY;
      key_q       <= '0;
      index_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      status_q    <= status_d;
      phase_q     <= phase_d;
      key_q       <= key_d;
      index_q     <= index_d;
      ready_q     <= ready_d;
    end
  end

  assign midi_index = index_q;
  assign midi_ready = ready_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_midi_note_rx.sv
// tb_midi_note_rx: directed and random MIDI byte streams checked against a
// byte-level model of the note-on rules (pulse key, pulse timing, framing).
module tb_midi_note_rx;

  localparam int CLK_FREQ = 3_125_000;
  localparam int BAUD     = 31250;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
  // Clock edges from the start-bit launch to the visible midi_ready pulse:
  // two synchroniser flops, one edge to leave IDLE, half a bit to mid start,
  // nine bit periods to the stop sample, one cycle in the parser.
  localparam int RDY_LAT  = 3 + HALF + 9 * BIT + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       midi_in = 1'b1;
  logic [6:0] midi_index;
  logic       midi_ready;
  logic       frame_err;

  midi_note_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .NOTE_MIN(48),
    .NOTE_MAX(79),
    .CHANNEL (0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .midi_in   (midi_in),
    .midi_index(midi_index),
    .midi_ready(midi_ready),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observed pulses (monitor only appends; the main block reads).
  int         rdy_cyc[$];
  logic [6:0] rdy_idx[$];
  int         fe_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (midi_ready === 1'b1) begin
        rdy_cyc.push_back(cyc);
        rdy_idx.push_back(midi_index);
      end
      if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: status 0=none 1=note-on 2=other.
  int         m_status = 0;
  bit         m_vel = 1'b0;
  int         m_key = 0;
  logic [6:0] m_index = 7'd0;
  int         exp_cyc[$];
  logic [6:0] exp_idx[$];
  int         exp_fe = 0;
  int         base_rdy = 0;
  int         base_fe = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop, input int t0);
    bit is_note_on;
    if (!stop) begin
      m_vel = 1'b0;
      exp_fe++;
    end else if (b >= 8'hF8) begin
      // real-time: no effect
    end else if (b >= 8'hF0) begin
      m_status = 0;
      m_vel = 1'b0;
    end else if (b >= 8'h80) begin
      is_note_on = (b[7:4] == 4'h9);
`ifdef MIDI_CHANNEL_FILTER_EN
      if (b[3:0] != 4'd0) is_note_on = 1'b0;
`endif
      m_status = is_note_on ? 1 : 2;
      m_vel = 1'b0;
    end else if (m_status == 1) begin
      if (!m_vel) begin
        m_key = int'(b);
        m_vel = 1'b1;
      end else begin
        m_vel = 1'b0;
        if (b != 8'd0 && m_key >= 48 && m_key <= 79) begin
          m_index = 7'(m_key);
          exp_cyc.push_back(t0 + RDY_LAT);
          exp_idx.push_back(7'(m_key));
        end
      end
    end
  endtask

  // Send one 8N1 frame; abort>0 cuts the frame after that many cycles.
  task automatic send_byte(input logic [7:0] b, input bit stop, input int abort);
    logic [9:0] frame;
    int t0;
    frame = {stop, b, 1'b0};
    @(negedge clock);
    t0 = cyc;
    if (abort == 0) model_byte(b, stop, t0);
    for (int k = 0; k < 10 * BIT; k++) begin
      if (abort != 0 && k == abort) break;
      midi_in = frame[k / BIT];
      @(negedge clock);
    end
    midi_in = 1'b1;
    if (!stop) repeat (BIT) @(negedge clock);
  endtask

  task automatic begin_step();
    exp_cyc.delete();
    exp_idx.delete();
    exp_fe   = 0;
    base_rdy = rdy_cyc.size();
    base_fe  = fe_cnt;
  endtask

  task automatic end_step(input string tag);
    int n;
    repeat (20) @(negedge clock);
    n = rdy_cyc.size() - base_rdy;
    chk({tag, "_ready_count"}, n, exp_cyc.size());
    for (int i = 0; i < n && i < exp_cyc.size(); i++) begin
      chk({tag, "_index"}, rdy_idx[base_rdy + i], exp_idx[i]);
      chk({tag, "_latency"}, rdy_cyc[base_rdy + i], exp_cyc[i]);
    end
    for (int i = 1; i < n; i++)
      chk({tag, "_gap_gt1"}, (rdy_cyc[base_rdy + i] - rdy_cyc[base_rdy + i - 1] > 1), 1);
    chk({tag, "_frame_err_count"}, fe_cnt - base_fe, exp_fe);
    chk({tag, "_index_hold"}, midi_index, m_index);
  endtask

  task automatic send_seq(input string tag, input logic [7:0] bytes[$]);
    begin_step();
    foreach (bytes[i]) send_byte(bytes[i], 1'b1, 0);
    end_step(tag);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 7))
      0: b = 8'h90 | 8'($urandom_range(0, 15));
      1: b = 8'($urandom_range(8'h80, 8'hEF));
      2: b = 8'($urandom_range(8'hF8, 8'hFF));
      3: b = 8'($urandom_range(8'hF0, 8'hF7));
      4, 5: b = 8'($urandom_range(44, 83));
      6: b = 8'($urandom_range(0, 127));
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  initial begin
    logic [7:0] b;
    bit stop;
    repeat (5) @(negedge clock);
    chk("reset_index", midi_index, 7'd0);
    chk("reset_ready", midi_ready, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    send_seq("note_on_60", '{8'h90, 8'h3C, 8'h40});
    send_seq("running_status_64", '{8'h40, 8'h7F});
    send_seq("vel_zero", '{8'h90, 8'h3C, 8'h00});
    send_seq("note_off_status", '{8'h80, 8'h3C, 8'h40});
    send_seq("key_below_range", '{8'h90, 8'h2F, 8'h40});
    send_seq("realtime_between", '{8'h90, 8'h3C, 8'hF8, 8'h40});

    // Short low glitch on an idle line.
    begin_step();
    @(negedge clock);
    midi_in = 1'b0;
    repeat (40) @(negedge clock);
    midi_in = 1'b1;
    repeat (200) @(negedge clock);
    end_step("glitch");

    // Bad stop bit on the velocity, then a clean key/velocity pair.
    begin_step();
    send_byte(8'h90, 1'b1, 0);
    send_byte(8'h3C, 1'b1, 0);
    send_byte(8'h40, 1'b0, 0);
    end_step("framing_error");
    send_seq("after_framing_62", '{8'h3E, 8'h40});

    // Random streams, occasionally with a broken stop bit.
    for (int s = 0; s < 4; s++) begin
      begin_step();
      for (int j = 0; j < 5; j++) begin
        b = rand_byte();
        stop = ($urandom_range(0, 9) != 0);
        send_byte(b, stop, 0);
      end
      end_step($sformatf("random_%0d", s));
    end

    send_seq("boundary_79", '{8'h90, 8'h4F, 8'h01});

    // Reset in the middle of a velocity byte.
    begin_step();
    send_byte(8'h90, 1'b1, 0);
    send_byte(8'h3C, 1'b1, 0);
    send_byte(8'h40, 1'b1, 500);
    reset = 1'b1;
    exp_cyc.delete();
    exp_idx.delete();
    m_status = 0;
    m_vel = 1'b0;
    m_key = 0;
    m_index = 7'd0;
    repeat (3) @(negedge clock);
    chk("midreset_index", midi_index, 7'd0);
    chk("midreset_ready", midi_ready, 1'b0);
    chk("midreset_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    end_step("mid_byte_reset");

    send_seq("data_without_status", '{8'h40, 8'h40});
    send_seq("boundary_48", '{8'h90, 8'h30, 8'h7F});
    send_seq("key_above_range", '{8'h90, 8'h50, 8'h40});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
